// File: rtl/pwm_hue_sequencer.sv
// pwm_hue_sequencer: walks R/G/B duty values around a six-phase hue wheel.
// One channel sits at full scale, one at zero, and the third ramps one count
// per step. Duty and phase outputs are registered from next-state values.
// Optional macro PWM_SEQ_DWELL_EN adds a hold period after each phase advance.
module pwm_hue_sequencer #(
  parameter int unsigned PWM_INTERVAL = 2000,
  parameter int unsigned STEP_TICKS   = 2000,
  parameter int unsigned DWELL_TICKS  = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] r_duty,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] g_duty,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] b_duty,
  output logic [2:0]                        phase,
  output logic                              cycle_done
);

  localparam int unsigned DW = $clog2(PWM_INTERVAL + 1);
  localparam int unsigned TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [DW-1:0] FULL      = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] RAMP_LAST = DW'(PWM_INTERVAL - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

  // Reject configurations the counters cannot represent
  if (PWM_INTERVAL < 2 || STEP_TICKS < 1 || DWELL_TICKS < 1) begin : g_cfg_check
    $error("pwm_hue_sequencer: invalid parameter configuration");
  end

  logic [DW-1:0] r_ramp;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_phase;

  logic [DW-1:0] w_ramp_nxt;
  logic [TW-1:0] w_tick_nxt;
  logic [2:0]    w_phase_nxt;
  logic          w_cycle_done_nxt;
  logic          w_in_ramp;
  logic [DW-1:0] w_up;
  logic [DW-1:0] w_dn;
  logic [DW-1:0] w_r_nxt;
  logic [DW-1:0] w_g_nxt;
  logic [DW-1:0] w_b_nxt;

`ifdef PWM_SEQ_DWELL_EN
  localparam int unsigned   DWW        = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_TICKS - 1);

  typedef enum logic {S_RAMP = 1'b0, S_DWELL = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [DWW-1:0] r_dwell;
  logic [DWW-1:0] w_dwell_nxt;

  assign w_in_ramp = (r_state == S_RAMP);
`else
  assign w_in_ramp = 1'b1;
`endif

  // State register: counters, phase, FSM state and the registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ramp     <= '0;
      r_tick     <= '0;
      r_phase    <= 3'd0;
      r_duty     <= FULL;
      g_duty     <= '0;
      b_duty     <= '0;
      phase      <= 3'd0;
      cycle_done <= 1'b0;
`ifdef PWM_SEQ_DWELL_EN
      r_state    <= S_RAMP;
      r_dwell    <= '0;
`endif
    end else begin
      r_ramp     <= w_ramp_nxt;
      r_tick     <= w_tick_nxt;
      r_phase    <= w_phase_nxt;
      r_duty     <= w_r_nxt;
      g_duty     <= w_g_nxt;
      b_duty     <= w_b_nxt;
      phase      <= w_phase_nxt;
      cycle_done <= w_cycle_done_nxt;
`ifdef PWM_SEQ_DWELL_EN
      r_state    <= w_state_nxt;
      r_dwell    <= w_dwell_nxt;
`endif
    end
  end

  // Next state: tick prescaler, ramp/phase stepping and optional dwell hold
  always_comb begin
    w_ramp_nxt       = r_ramp;
    w_tick_nxt       = r_tick;
    w_phase_nxt      = r_phase;
    w_cycle_done_nxt = 1'b0;
`ifdef PWM_SEQ_DWELL_EN
    w_state_nxt      = r_state;
    w_dwell_nxt      = r_dwell;
    if (en && (r_state == S_DWELL)) begin
      if (r_dwell == DWELL_LAST) begin
        w_state_nxt = S_RAMP;
        w_dwell_nxt = '0;
        w_tick_nxt  = '0;
      end else begin
        w_dwell_nxt = r_dwell + DWW'(1);
      end
    end
`endif
    if (en && w_in_ramp) begin
      if (r_tick == TICK_LAST) begin
        w_tick_nxt = '0;
        if (r_ramp == RAMP_LAST) begin
          w_ramp_nxt       = '0;
          w_phase_nxt      = (r_phase == 3'd5) ? 3'd0 : r_phase + 3'd1;
          w_cycle_done_nxt = (r_phase == 3'd5);
`ifdef PWM_SEQ_DWELL_EN
          w_state_nxt      = S_DWELL;
`endif
        end else begin
          w_ramp_nxt = r_ramp + DW'(1);
        end
      end else begin
        w_tick_nxt = r_tick + TW'(1);
      end
    end
  end

  // Output map: duty triple for the next phase/ramp (ramp <= FULL-1, so dn never underflows)
  always_comb begin
    w_up    = w_ramp_nxt;
    w_dn    = FULL - w_ramp_nxt;
    w_r_nxt = FULL;
    w_g_nxt = '0;
    w_b_nxt = '0;
    case (w_phase_nxt)
      3'd0: begin w_r_nxt = FULL; w_g_nxt = w_up; w_b_nxt = '0;   end
      3'd1: begin w_r_nxt = w_dn; w_g_nxt = FULL; w_b_nxt = '0;   end
      3'd2: begin w_r_nxt = '0;   w_g_nxt = FULL; w_b_nxt = w_up; end
      3'd3: begin w_r_nxt = '0;   w_g_nxt = w_dn; w_b_nxt = FULL; end
      3'd4: begin w_r_nxt = w_up; w_g_nxt = '0;   w_b_nxt = FULL; end
      3'd5: begin w_r_nxt = FULL; w_g_nxt = '0;   w_b_nxt = w_dn; end
      default: begin w_r_nxt = FULL; w_g_nxt = '0; w_b_nxt = '0;  end
    endcase
  end

endmodule

// File: tb/tb_pwm_hue_sequencer.sv
// Bench for pwm_hue_sequencer (default build, dwell macro undefined).
// Model: duties derived from the count of enabled edges since reset.
module tb_pwm_hue_sequencer;

  localparam int M      = 4;
  localparam int ST     = 3;
  localparam int DT     = 5;
  localparam int DW     = $clog2(M + 1);
  localparam int PERIOD = 6 * M * ST;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [DW-1:0] r_duty;
  logic [DW-1:0] g_duty;
  logic [DW-1:0] b_duty;
  logic [2:0]    phase;
  logic          cycle_done;

  int n_checks = 0;
  int n_fail   = 0;

  int m_n     = 0;
  bit m_cd    = 1'b0;
  bit m_valid = 1'b0;
  bit prev_ok = 1'b0;
  int pr, pg, pb;

  pwm_hue_sequencer #(
    .PWM_INTERVAL(M),
    .STEP_TICKS  (ST),
    .DWELL_TICKS (DT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .r_duty    (r_duty),
    .g_duty    (g_duty),
    .b_duty    (b_duty),
    .phase     (phase),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_delta(input string name, input int cur, input int prev);
    int d;
    d = (cur > prev) ? cur - prev : prev - cur;
    n_checks++;
    if (d > 1) begin
      n_fail++;
      $display("FAIL %s: step of %0d counts (%0d -> %0d) expected at most 1 at %0t",
               name, d, prev, cur, $time);
    end
  endtask

  // Hue wheel position from the number of enabled edges since reset
  function automatic void model_duty(input int n, output int r, output int g,
                                     output int b, output int ph);
    int s, up, dn;
    s  = n / ST;
    ph = (s / M) % 6;
    up = s % M;
    dn = M - up;
    case (ph)
      0: begin r = M;  g = up; b = 0;  end
      1: begin r = dn; g = M;  b = 0;  end
      2: begin r = 0;  g = M;  b = up; end
      3: begin r = 0;  g = dn; b = M;  end
      4: begin r = up; g = 0;  b = M;  end
      default: begin r = M; g = 0; b = dn; end
    endcase
  endfunction

  // Model update on each edge, then compare DUT outputs 1 time unit later
  always @(posedge clk) begin
    bit was_rst;
    int er, eg, eb, ep;
    was_rst = rst;
    if (rst) begin
      m_n     = 0;
      m_cd    = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (en) begin
        m_n++;
        m_cd = ((m_n % PERIOD) == 0);
      end else begin
        m_cd = 1'b0;
      end
    end
    #1;
    if (m_valid) begin
      model_duty(m_n, er, eg, eb, ep);
      check("r_duty", 32'(r_duty), 32'(er));
      check("g_duty", 32'(g_duty), 32'(eg));
      check("b_duty", 32'(b_duty), 32'(eb));
      check("phase", 32'(phase), 32'(ep));
      check("cycle_done", 32'(cycle_done), 32'(m_cd));
      if (prev_ok && !was_rst) begin
        check_delta("r_delta", int'(r_duty), pr);
        check_delta("g_delta", int'(g_duty), pg);
        check_delta("b_delta", int'(b_duty), pb);
      end
      pr = int'(r_duty);
      pg = int'(g_duty);
      pb = int'(b_duty);
      prev_ok = 1'b1;
    end
  end

  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_r", 32'(r_duty), 32'd4);
    check("idle_g", 32'(g_duty), 32'd0);
    check("idle_b", 32'(b_duty), 32'd0);
    check("idle_phase", 32'(phase), 32'd0);
    check("idle_cd", 32'(cycle_done), 32'd0);

    en = 1'b1;
    edges(3);  check("g_at_3", 32'(g_duty), 32'd1);
    edges(3);  check("g_at_6", 32'(g_duty), 32'd2);
    edges(3);  check("g_at_9", 32'(g_duty), 32'd3);
    edges(3);
    check("phase_at_12", 32'(phase), 32'd1);
    check("r_at_12", 32'(r_duty), 32'd4);
    check("g_at_12", 32'(g_duty), 32'd4);
    check("b_at_12", 32'(b_duty), 32'd0);
    edges(3);  check("r_at_15", 32'(r_duty), 32'd3);
    edges(56); check("cd_at_71", 32'(cycle_done), 32'd0);
    edges(1);
    check("cd_at_72", 32'(cycle_done), 32'd1);
    check("phase_at_72", 32'(phase), 32'd0);
    check("r_at_72", 32'(r_duty), 32'd4);
    check("g_at_72", 32'(g_duty), 32'd0);
    check("b_at_72", 32'(b_duty), 32'd0);
    edges(1);  check("cd_at_73", 32'(cycle_done), 32'd0);

    // Pause: two enabled edges, ten frozen, then one more completes the step
    @(negedge clk); rst = 1'b1; en = 1'b0;
    @(negedge clk); rst = 1'b0; en = 1'b1;
    edges(2);
    @(negedge clk); en = 1'b0;
    repeat (10) @(negedge clk);
    check("g_paused", 32'(g_duty), 32'd0);
    en = 1'b1;
    edges(1);  check("g_after_resume", 32'(g_duty), 32'd1);

    // Reset in the middle of phase 3 with en held high
    edges(38); check("phase_mid3", 32'(phase), 32'd3);
    @(negedge clk); rst = 1'b1;
    edges(1);
    check("rst_r", 32'(r_duty), 32'd4);
    check("rst_g", 32'(g_duty), 32'd0);
    check("rst_b", 32'(b_duty), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_cd", 32'(cycle_done), 32'd0);
    @(negedge clk); rst = 1'b0;
    edges(2);  check("g_post_rst_2", 32'(g_duty), 32'd0);
    edges(1);  check("g_post_rst_3", 32'(g_duty), 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
